// File: rtl/pwm_cfgreg_bank_if.sv
// rtl/pwm_cfgreg_bank_if.sv - register write/read bus for the PWM configuration bank
// Readback signals exist only when CFG_READBACK_EN is defined.
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

interface pwm_cfgreg_bank_if #(
  parameter int N_CH      = 4,
  parameter int REG_WIDTH = `PWMCOUNT_WIDTH
);
  localparam int CH_AW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic                   wr_en;
  logic [CH_AW-1:0]       wr_ch;
  logic [REG_WIDTH-1:0]   wr_data;
  logic [REG_WIDTH/8-1:0] wr_strb;
  logic                   wr_ack;
  logic                   wr_err;
`ifdef CFG_READBACK_EN
  logic                   rd_en;
  logic [CH_AW-1:0]       rd_ch;
  logic                   rd_sel;
  logic [REG_WIDTH-1:0]   rd_data;
  logic                   rd_valid;
`endif

  modport master (
    output wr_en, wr_ch, wr_data, wr_strb,
    input  wr_ack, wr_err
`ifdef CFG_READBACK_EN
    , output rd_en, rd_ch, rd_sel
    , input  rd_data, rd_valid
`endif
  );

  modport slave (
    input  wr_en, wr_ch, wr_data, wr_strb,
    output wr_ack, wr_err
`ifdef CFG_READBACK_EN
    , input  rd_en, rd_ch, rd_sel
    , output rd_data, rd_valid
`endif
  );
endinterface

// File: rtl/pwm_cfgreg_bank.sv
// rtl/pwm_cfgreg_bank.sv - per-channel PWM control word bank with shadow/active double buffering
// Optional readback port enabled by defining CFG_READBACK_EN.
`ifndef PWMCOUNT_WIDTH
`define PWMCOUNT_WIDTH 16
`endif

module pwm_cfgreg_bank #(
  parameter int N_CH      = 4,
  parameter int REG_WIDTH = `PWMCOUNT_WIDTH,
  parameter int CH_AW     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                reset,
  pwm_cfgreg_bank_if.slave    bus,
  input  logic [N_CH-1:0]     upd_evt,
  input  logic                force_load,
  output logic [N_CH-1:0]     pending,
  output logic [N_CH-1:0]     cfg_loaded,
  output logic [2*N_CH-1:0]   count_mode,
  output logic [2*N_CH-1:0]   mask_mode,
  output logic [N_CH-1:0]     pwmclkdiv_onoff,
  output logic [N_CH-1:0]     dtclkdiv_onoff,
  output logic [N_CH-1:0]     int_onoff,
  output logic [N_CH-1:0]     pwm_onoff,
  output logic [N_CH-1:0]     logic_A,
  output logic [N_CH-1:0]     logic_B
);
  localparam int CFG_W = 11;

  logic [CFG_W-1:0] shadow [N_CH];
  logic [CFG_W-1:0] active [N_CH];
  logic [CFG_W-1:0] merged [N_CH];
  logic [N_CH-1:0]  wr_hit;
  logic [N_CH-1:0]  load_req;
  logic [N_CH-1:0]  imm_bits;
  logic             wr_in_range;
  logic             wr_any_strb;
  logic             unused_bits;

  always_comb begin
    wr_in_range = 32'(bus.wr_ch) < N_CH;
    wr_any_strb = bus.wr_strb[0] | bus.wr_strb[1];
    wr_hit      = '0;
    load_req    = '0;
    for (int k = 0; k < N_CH; k++) begin
      wr_hit[k]   = bus.wr_en && wr_any_strb && (bus.wr_ch == CH_AW'(k));
      load_req[k] = pending[k] && (upd_evt[k] || force_load);
      merged[k]   = shadow[k];
      if (bus.wr_strb[0]) merged[k][7:0]  = bus.wr_data[7:0];
      if (bus.wr_strb[1]) merged[k][10:8] = bus.wr_data[10:8];
    end
  end

  // A deferred write colliding with a load lets the old shadow through and re-arms pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < N_CH; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
      pending     <= '0;
      cfg_loaded  <= '0;
      bus.wr_ack  <= 1'b0;
      bus.wr_err  <= 1'b0;
    end else begin
      bus.wr_ack <= bus.wr_en && wr_in_range;
      bus.wr_err <= bus.wr_en && !wr_in_range;
      cfg_loaded <= '0;
      for (int k = 0; k < N_CH; k++) begin
        if (wr_hit[k]) begin
          shadow[k] <= merged[k];
          if (merged[k][10]) begin
            active[k]     <= merged[k];
            pending[k]    <= 1'b0;
            cfg_loaded[k] <= 1'b1;
          end else begin
            pending[k] <= 1'b1;
            if (load_req[k]) begin
              active[k]     <= shadow[k];
              cfg_loaded[k] <= 1'b1;
            end
          end
        end else if (load_req[k]) begin
          active[k]     <= shadow[k];
          pending[k]    <= 1'b0;
          cfg_loaded[k] <= 1'b1;
        end
      end
    end
  end

`ifdef CFG_READBACK_EN
  logic [CFG_W-1:0] rd_word;

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (bus.rd_ch == CH_AW'(k)) rd_word = bus.rd_sel ? shadow[k] : active[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rd_data  <= '0;
      bus.rd_valid <= 1'b0;
    end else begin
      bus.rd_valid <= bus.rd_en;
      bus.rd_data  <= bus.rd_en ? {{(REG_WIDTH-CFG_W){1'b0}}, rd_word} : '0;
    end
  end
`endif

  // Field buses are straight wiring of the active registers, so they change on the load edge.
  always_comb begin
    count_mode      = '0;
    mask_mode       = '0;
    pwmclkdiv_onoff = '0;
    dtclkdiv_onoff  = '0;
    int_onoff       = '0;
    pwm_onoff       = '0;
    logic_A         = '0;
    logic_B         = '0;
    imm_bits        = '0;
    for (int k = 0; k < N_CH; k++) begin
      count_mode[2*k +: 2] = active[k][1:0];
      mask_mode[2*k +: 2]  = active[k][3:2];
      pwmclkdiv_onoff[k]   = active[k][4];
      dtclkdiv_onoff[k]    = active[k][5];
      int_onoff[k]         = active[k][6];
      pwm_onoff[k]         = active[k][7];
      logic_A[k]           = active[k][8];
      logic_B[k]           = active[k][9];
      imm_bits[k]          = active[k][10];
    end
  end

  assign unused_bits = ^{bus.wr_data, bus.wr_strb, imm_bits};

endmodule

// File: tb/tb_pwm_cfgreg_bank.sv
// tb/tb_pwm_cfgreg_bank.sv - directed and randomized check of pwm_cfgreg_bank against a rule-level model
module tb_pwm_cfgreg_bank;
  localparam int N  = 5;
  localparam int RW = 16;
  localparam int AW = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   upd_evt;
  logic           force_load;
  logic [N-1:0]   pending, cfg_loaded;
  logic [2*N-1:0] count_mode, mask_mode;
  logic [N-1:0]   pwmclkdiv_onoff, dtclkdiv_onoff, int_onoff, pwm_onoff, logic_A, logic_B;

  pwm_cfgreg_bank_if #(.N_CH(N), .REG_WIDTH(RW)) bus ();

  pwm_cfgreg_bank #(.N_CH(N), .REG_WIDTH(RW), .CH_AW(AW)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .upd_evt(upd_evt), .force_load(force_load),
    .pending(pending), .cfg_loaded(cfg_loaded),
    .count_mode(count_mode), .mask_mode(mask_mode),
    .pwmclkdiv_onoff(pwmclkdiv_onoff), .dtclkdiv_onoff(dtclkdiv_onoff),
    .int_onoff(int_onoff), .pwm_onoff(pwm_onoff),
    .logic_A(logic_A), .logic_B(logic_B)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [10:0]   m_sh [N];
  logic [10:0]   m_act [N];
  logic [N-1:0]  m_pend, m_loaded;
  logic          m_ack, m_err, m_rv;
  logic [RW-1:0] m_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic compare_all();
    logic [2*N-1:0] e_cm, e_mm;
    logic [N-1:0]   e_b [8];
    for (int k = 0; k < N; k++) begin
      e_cm[2*k +: 2] = m_act[k][1:0];
      e_mm[2*k +: 2] = m_act[k][3:2];
      for (int b = 0; b < 6; b++) e_b[b][k] = m_act[k][4+b];
    end
    check("wr_ack", 32'(bus.wr_ack), 32'(m_ack));
    check("wr_err", 32'(bus.wr_err), 32'(m_err));
    check("pending", 32'(pending), 32'(m_pend));
    check("cfg_loaded", 32'(cfg_loaded), 32'(m_loaded));
    check("count_mode", 32'(count_mode), 32'(e_cm));
    check("mask_mode", 32'(mask_mode), 32'(e_mm));
    check("pwmclkdiv", 32'(pwmclkdiv_onoff), 32'(e_b[0]));
    check("dtclkdiv", 32'(dtclkdiv_onoff), 32'(e_b[1]));
    check("int_onoff", 32'(int_onoff), 32'(e_b[2]));
    check("pwm_onoff", 32'(pwm_onoff), 32'(e_b[3]));
    check("logic_A", 32'(logic_A), 32'(e_b[4]));
    check("logic_B", 32'(logic_B), 32'(e_b[5]));
`ifdef CFG_READBACK_EN
    check("rd_valid", 32'(bus.rd_valid), 32'(m_rv));
    check("rd_data", 32'(bus.rd_data), 32'(m_rd));
`endif
  endtask

  // One clock of stimulus: drive, advance the model by the written rules, then compare.
  task automatic cycle(input logic rst, input logic en, input logic [AW-1:0] ch,
                       input logic [RW-1:0] data, input logic [1:0] strb,
                       input logic [N-1:0] evt, input logic frc,
                       input logic ren, input logic [AW-1:0] rch, input logic rsel);
    logic [10:0] word;
    @(negedge clk);
    reset = rst; bus.wr_en = en; bus.wr_ch = ch; bus.wr_data = data; bus.wr_strb = strb;
    upd_evt = evt; force_load = frc;
`ifdef CFG_READBACK_EN
    bus.rd_en = ren; bus.rd_ch = rch; bus.rd_sel = rsel;
`endif
    if (rst) begin
      for (int k = 0; k < N; k++) begin m_sh[k] = '0; m_act[k] = '0; end
      m_pend = '0; m_loaded = '0; m_ack = 0; m_err = 0; m_rv = 0; m_rd = '0;
    end else begin
      m_rv = ren;
      m_rd = '0;
      if (ren && int'(rch) < N) m_rd = RW'(rsel ? m_sh[rch] : m_act[rch]);
      m_ack = en && int'(ch) < N;
      m_err = en && int'(ch) >= N;
      m_loaded = '0;
      for (int k = 0; k < N; k++) begin
        if (m_pend[k] && (evt[k] || frc)) begin
          m_act[k] = m_sh[k]; m_pend[k] = 0; m_loaded[k] = 1;
        end
      end
      if (m_ack && strb != 2'b00) begin
        word = m_sh[ch];
        if (strb[0]) word[7:0]  = data[7:0];
        if (strb[1]) word[10:8] = data[10:8];
        m_sh[ch] = word;
        if (word[10]) begin
          m_act[ch] = word; m_pend[ch] = 0; m_loaded[ch] = 1;
        end else begin
          m_pend[ch] = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input logic [N-1:0] evt, input logic frc);
    cycle(0, 0, '0, '0, 2'b00, evt, frc, 0, '0, 0);
  endtask

  task automatic wr(input logic [AW-1:0] ch, input logic [RW-1:0] data, input logic [1:0] strb,
                    input logic [N-1:0] evt);
    cycle(0, 1, ch, data, strb, evt, 0, 0, '0, 0);
  endtask

  initial begin
    reset = 1; bus.wr_en = 0; bus.wr_ch = '0; bus.wr_data = '0; bus.wr_strb = '0;
    upd_evt = '0; force_load = 0;
`ifdef CFG_READBACK_EN
    bus.rd_en = 0; bus.rd_ch = '0; bus.rd_sel = 0;
`endif
    // Reset held two cycles while a write is presented
    cycle(1, 1, 3'd1, 16'h04C5, 2'b11, '0, 0, 0, '0, 0);
    cycle(1, 1, 3'd1, 16'h04C5, 2'b11, '0, 0, 0, '0, 0);
    check("rst_pending", 32'(pending), 32'h0);
    check("rst_ack", 32'(bus.wr_ack), 32'h0);
    check("rst_pwm", 32'(pwm_onoff), 32'h0);

    // Immediate write
    wr(3'd1, 16'h04C5, 2'b11, '0);
    check("imm_ack", 32'(bus.wr_ack), 32'h1);
    check("imm_loaded", 32'(cfg_loaded), 32'h02);
    check("imm_count", 32'(count_mode[3:2]), 32'h1);
    check("imm_mask", 32'(mask_mode[3:2]), 32'h1);
    check("imm_pwm", 32'(pwm_onoff[1]), 32'h1);
    check("imm_int", 32'(int_onoff[1]), 32'h1);
    check("imm_logicA", 32'(logic_A[1]), 32'h0);
    check("imm_logicB", 32'(logic_B[1]), 32'h0);

    // Deferred write, event five cycles later
    wr(3'd2, 16'h0083, 2'b11, '0);
    check("def_pend0", 32'(pending[2]), 32'h1);
    for (int i = 0; i < 4; i++) begin
      idle('0, 0);
      check("def_pend_wait", 32'(pending[2]), 32'h1);
    end
    idle(5'b00100, 0);
    check("def_count", 32'(count_mode[5:4]), 32'h3);
    check("def_pwm", 32'(pwm_onoff[2]), 32'h1);
    check("def_pend1", 32'(pending[2]), 32'h0);
`ifdef CFG_READBACK_EN
    cycle(0, 0, '0, '0, 2'b00, '0, 0, 1, 3'd2, 1);
    check("rb_shadow", 32'(bus.rd_data), 32'h083);
    check("rb_valid", 32'(bus.rd_valid), 32'h1);
    cycle(0, 0, '0, '0, 2'b00, '0, 0, 1, 3'd2, 0);
    check("rb_active", 32'(bus.rd_data), 32'h083);
    cycle(0, 0, '0, '0, 2'b00, '0, 0, 1, 3'd6, 1);
    check("rb_range", 32'(bus.rd_data), 32'h0);
`endif

    // Collision of deferred write and update event on ch0
    wr(3'd0, 16'h0011, 2'b11, '0);
    wr(3'd0, 16'h0022, 2'b11, 5'b00001);
    check("col_count", 32'(count_mode[1:0]), 32'h1);
    check("col_pend", 32'(pending[0]), 32'h1);
    check("col_loaded", 32'(cfg_loaded[0]), 32'h1);

    // Strobe handling, out-of-range channel, zero strobe, force_load
    wr(3'd3, 16'h04FF, 2'b11, '0);
    wr(3'd3, 16'h03AA, 2'b10, '0);
    check("strb_pend", 32'(pending[3]), 32'h1);
    check("strb_count", 32'(count_mode[7:6]), 32'h3);
    wr(3'd5, 16'h07FF, 2'b11, '0);
    check("range_err", 32'(bus.wr_err), 32'h1);
    check("range_ack", 32'(bus.wr_ack), 32'h0);
    wr(3'd1, 16'h0000, 2'b00, '0);
    check("zstrb_ack", 32'(bus.wr_ack), 32'h1);
    check("zstrb_loaded", 32'(cfg_loaded), 32'h0);
    wr(3'd4, 16'h0005, 2'b11, '0);
    check("fl_pre", 32'(pending), 32'h19);
    idle('0, 1);
    check("fl_loaded", 32'(cfg_loaded), 32'h19);
    check("fl_pend", 32'(pending), 32'h0);
    check("fl_ch3A", 32'(logic_A[3]), 32'h1);
    check("fl_ch0cnt", 32'(count_mode[1:0]), 32'h2);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] evt;
      evt = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, AW'($urandom),
            RW'($urandom), 2'($urandom), evt, $urandom_range(0, 19) == 0,
            1'($urandom), AW'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
